// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the host-side run sequencer.
package run_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, INIT, RUN, DRAIN} run_state_t;

  localparam logic [15:0] RUN_TIMEOUT_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/run_ctrl.sv
// Host run sequencer: load bytes into data memory, pulse core START, time the run, drain results.
// Load/drain move 1 byte/cycle with 0-cycle memory read; in_ready/out_valid stall only the index.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter logic [7:0]  LOAD_BASE    = 8'd0,
  parameter logic [8:0]  LOAD_LEN     = 9'd64,
  parameter logic [7:0]  OUT_BASE     = 8'd64,
  parameter logic [8:0]  OUT_LEN      = 9'd64,
  parameter logic [3:0]  START_CYCLES = 4'd2,
  parameter logic [15:0] TIMEOUT      = RUN_TIMEOUT_DEFAULT
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        go,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        START,
  input  logic        DONE,
  output logic        mem_own,
  output logic [7:0]  mem_addr,
  output logic        mem_wen,
  output logic        mem_ren,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        timed_out,
  output logic [15:0] cycle_count
);

  localparam logic [8:0]  LOAD_LAST = LOAD_LEN - 9'd1;
  localparam logic [8:0]  OUT_LAST  = OUT_LEN - 9'd1;
  localparam logic [8:0]  INIT_LAST = {5'd0, START_CYCLES} - 9'd1;
  localparam logic [15:0] TO_LAST   = TIMEOUT - 16'd1;

  run_state_t  state, state_nxt;
  logic [8:0]  idx, idx_nxt;
  logic [15:0] cycle_count_nxt;
  logic        timed_out_nxt;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= 9'd0;
      cycle_count <= 16'd0;
      timed_out   <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cycle_count <= cycle_count_nxt;
      timed_out   <= timed_out_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    cycle_count_nxt = cycle_count;
    timed_out_nxt   = timed_out;
    START           = 1'b1;
    mem_own         = 1'b1;
    in_ready        = 1'b0;
    out_valid       = 1'b0;
    mem_wen         = 1'b0;
    mem_ren         = 1'b0;
    mem_addr        = 8'd0;
    mem_wdata       = 8'd0;
    out_data        = 8'd0;

    case (state)
      IDLE: begin
        if (go) begin
          idx_nxt         = 9'd0;
          cycle_count_nxt = 16'd0;
          timed_out_nxt   = 1'b0;
          state_nxt       = (LOAD_LEN == 9'd0) ? INIT : LOAD;
        end
      end
      LOAD: begin
        in_ready  = 1'b1;
        mem_addr  = LOAD_BASE + idx[7:0];
        mem_wdata = in_data;
        mem_wen   = in_valid;
        if (in_valid) begin
          if (idx == LOAD_LAST) begin
            idx_nxt   = 9'd0;
            state_nxt = INIT;
          end else begin
            idx_nxt = idx + 9'd1;
          end
        end
      end
      // idx doubles as the START hold counter and is left at 0 for the drain.
      INIT: begin
        if (idx == INIT_LAST) begin
          idx_nxt   = 9'd0;
          state_nxt = RUN;
        end else begin
          idx_nxt = idx + 9'd1;
        end
      end
      RUN: begin
        START   = 1'b0;
        mem_own = 1'b0;
        if (cycle_count != 16'hFFFF) begin
          cycle_count_nxt = cycle_count + 16'd1;
        end
        // cycle_count is 0 only in the first RUN cycle, where DONE is ignored.
        if (DONE && (cycle_count != 16'd0)) begin
          state_nxt = (OUT_LEN == 9'd0) ? IDLE : DRAIN;
        end else if (cycle_count == TO_LAST) begin
          timed_out_nxt = 1'b1;
          state_nxt     = (OUT_LEN == 9'd0) ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        mem_ren   = 1'b1;
        out_valid = 1'b1;
        mem_addr  = OUT_BASE + idx[7:0];
        out_data  = mem_rdata;
        if (out_ready) begin
          if (idx == OUT_LAST) begin
            idx_nxt   = 9'd0;
            state_nxt = IDLE;
          end else begin
            idx_nxt = idx + 9'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: two parameterisations, table-driven run scenarios, reset/abort sequences,
// and randomized runs scored against a transaction-level model of load/run/drain.
module tb_run_ctrl;

  localparam logic [7:0]  A_LB = 8'h10, B_LB = 8'h00;
  localparam logic [8:0]  A_LL = 9'd4,  B_LL = 9'd0;
  localparam logic [7:0]  A_OB = 8'hFE, B_OB = 8'h40;
  localparam logic [8:0]  A_OL = 9'd3,  B_OL = 9'd2;
  localparam logic [3:0]  A_SC = 4'd2,  B_SC = 4'd3;
  localparam logic [15:0] A_TO = 16'd100, B_TO = 16'd8;

  logic        clk;
  logic        rst_s [2];
  logic        go_s  [2];
  logic        iv_s  [2];
  logic [7:0]  id_s  [2];
  logic        ir_s  [2];
  logic        ov_s  [2];
  logic [7:0]  od_s  [2];
  logic        or_s  [2];
  logic        st_s  [2];
  logic        dn_s  [2];
  logic        own_s [2];
  logic [7:0]  addr_s[2];
  logic        wen_s [2];
  logic        ren_s [2];
  logic [7:0]  wd_s  [2];
  logic [7:0]  rd_s  [2];
  logic        busy_s[2];
  logic        to_s  [2];
  logic [15:0] cc_s  [2];

  int p_lb[2], p_ll[2], p_ob[2], p_ol[2], p_sc[2], p_to[2];

  logic [7:0] mem     [2][256];
  logic [7:0] ref_mem [2][256];
  logic       bd_we;
  logic [7:0] bd_addr, bd_dat;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int d; int done_at; int vld; int rdy; int exp_cc; int exp_to;
  } vec_t;
  vec_t tbl[8];

  run_ctrl #(.LOAD_BASE(A_LB), .LOAD_LEN(A_LL), .OUT_BASE(A_OB), .OUT_LEN(A_OL),
             .START_CYCLES(A_SC), .TIMEOUT(A_TO)) u_a (
    .CLK(clk), .reset(rst_s[0]), .go(go_s[0]), .in_valid(iv_s[0]), .in_data(id_s[0]),
    .in_ready(ir_s[0]), .out_valid(ov_s[0]), .out_data(od_s[0]), .out_ready(or_s[0]),
    .START(st_s[0]), .DONE(dn_s[0]), .mem_own(own_s[0]), .mem_addr(addr_s[0]),
    .mem_wen(wen_s[0]), .mem_ren(ren_s[0]), .mem_wdata(wd_s[0]), .mem_rdata(rd_s[0]),
    .busy(busy_s[0]), .timed_out(to_s[0]), .cycle_count(cc_s[0]));

  run_ctrl #(.LOAD_BASE(B_LB), .LOAD_LEN(B_LL), .OUT_BASE(B_OB), .OUT_LEN(B_OL),
             .START_CYCLES(B_SC), .TIMEOUT(B_TO)) u_b (
    .CLK(clk), .reset(rst_s[1]), .go(go_s[1]), .in_valid(iv_s[1]), .in_data(id_s[1]),
    .in_ready(ir_s[1]), .out_valid(ov_s[1]), .out_data(od_s[1]), .out_ready(or_s[1]),
    .START(st_s[1]), .DONE(dn_s[1]), .mem_own(own_s[1]), .mem_addr(addr_s[1]),
    .mem_wen(wen_s[1]), .mem_ren(ren_s[1]), .mem_wdata(wd_s[1]), .mem_rdata(rd_s[1]),
    .busy(busy_s[1]), .timed_out(to_s[1]), .cycle_count(cc_s[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory behind each block, with a backdoor port used only during reset.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (own_s[k] && wen_s[k]) mem[k][addr_s[k]] <= wd_s[k];
      else if (bd_we)           mem[k][bd_addr]   <= bd_dat;
    end
  end

  always_comb begin
    rd_s[0] = mem[0][addr_s[0]];
    rd_s[1] = mem[1][addr_s[1]];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Spec-level run outcome: DONE counts from RUN cycle 2, timeout fires at cycle TIMEOUT, DONE wins ties.
  task automatic model_run(input int to, input int done_at, output int exp_cc, output int exp_to);
    int eff;
    eff    = (done_at == 0) ? 32'h3FFF_FFFF : ((done_at < 2) ? 2 : done_at);
    exp_cc = (eff < to) ? eff : to;
    exp_to = (eff > to) ? 1 : 0;
  endtask

  task automatic run_seq(input int d, input int done_at, input int vld_pct, input int rdy_pct,
                         input int abort_at, input int exp_cc, input int exp_to);
    logic [7:0] bytes[$];
    int i, g, st, rn, hs, bad_bus, a;
    logic [7:0] pa, pd;
    logic stall, aborted;
    g = 0; bad_bus = 0; stall = 1'b0; aborted = 1'b0; pa = 8'd0; pd = 8'd0;
    for (int k = 0; k < p_ll[d]; k++) bytes.push_back(8'($urandom));

    @(negedge clk); go_s[d] = 1'b1; #2;
    chk("idle_before_go", busy_s[d], 0);
    @(negedge clk); go_s[d] = 1'b0; #1;

    i = 0;
    while (i < p_ll[d] && g < 1000) begin
      iv_s[d] = ($urandom_range(99) < vld_pct);
      id_s[d] = bytes[i];
      #1;
      if (iv_s[d]) begin
        a = (p_lb[d] + i) % 256;
        chk("load_addr", addr_s[d], a);
        chk("load_data", wd_s[d], bytes[i]);
        chk("load_strobe", {own_s[d], wen_s[d], ir_s[d]}, 3'b111);
        ref_mem[d][a] = bytes[i];
        i++;
      end else if (wen_s[d] || !ir_s[d]) begin
        bad_bus++;
      end
      @(negedge clk); #1; g++;
    end
    iv_s[d] = 1'b0;
    chk("load_count", i, p_ll[d]);

    st = 0;
    while (g < 1000 && st_s[d] && busy_s[d]) begin
      if (ir_s[d] || ov_s[d] || !own_s[d] || wen_s[d] || ren_s[d]) bad_bus++;
      st++;
      @(negedge clk); #1; g++;
    end
    chk("start_cycles", st, p_sc[d]);

    rn = 0;
    while (g < 1000 && busy_s[d] && !st_s[d]) begin
      rn++;
      dn_s[d] = (done_at != 0 && rn >= done_at);
      if (own_s[d] || wen_s[d] || ren_s[d]) bad_bus++;
      @(negedge clk); #1; g++;
    end
    dn_s[d] = 1'b0;
    chk("run_cycles", rn, exp_cc);
    chk("cycle_count", cc_s[d], exp_cc);
    chk("timed_out", to_s[d], exp_to);
    chk("own_after_run", own_s[d], 1);

    hs = 0;
    while (g < 1000 && busy_s[d]) begin
      if (abort_at > 0 && hs == abort_at) begin
        rst_s[d] = 1'b1; #1;
        chk("abort_busy", busy_s[d], 0);
        chk("abort_out_valid", ov_s[d], 0);
        chk("abort_start", st_s[d], 1);
        @(negedge clk); rst_s[d] = 1'b0; #1;
        aborted = 1'b1;
        break;
      end
      or_s[d] = ($urandom_range(99) < rdy_pct);
      #1;
      if (!ov_s[d] || !ren_s[d] || !own_s[d] || !st_s[d] || wen_s[d]) bad_bus++;
      if (stall) begin
        chk("stall_addr", addr_s[d], pa);
        chk("stall_data", od_s[d], pd);
      end
      if (or_s[d]) begin
        a = (p_ob[d] + hs) % 256;
        chk("drain_addr", addr_s[d], a);
        chk("drain_data", od_s[d], ref_mem[d][a]);
        hs++;
      end
      stall = !or_s[d]; pa = addr_s[d]; pd = od_s[d];
      @(negedge clk); #1; g++;
    end
    or_s[d] = 1'b0;
    if (!aborted) begin
      chk("handshakes", hs, p_ol[d]);
      chk("idle_after", {busy_s[d], ov_s[d]}, 0);
    end
    chk("bus_rules", bad_bus, 0);
  endtask

  initial begin
    int ecc, eto, d, da;
    p_lb = '{int'(A_LB), int'(B_LB)}; p_ll = '{int'(A_LL), int'(B_LL)};
    p_ob = '{int'(A_OB), int'(B_OB)}; p_ol = '{int'(A_OL), int'(B_OL)};
    p_sc = '{int'(A_SC), int'(B_SC)}; p_to = '{int'(A_TO), int'(B_TO)};

    tbl[0] = '{d:0, done_at:37, vld:60,  rdy:50,  exp_cc:37,  exp_to:0};
    tbl[1] = '{d:0, done_at:1,  vld:100, rdy:100, exp_cc:2,   exp_to:0};
    tbl[2] = '{d:1, done_at:0,  vld:100, rdy:50,  exp_cc:8,   exp_to:1};
    tbl[3] = '{d:1, done_at:8,  vld:100, rdy:50,  exp_cc:8,   exp_to:0};
    tbl[4] = '{d:1, done_at:9,  vld:100, rdy:40,  exp_cc:8,   exp_to:1};
    tbl[5] = '{d:1, done_at:3,  vld:100, rdy:60,  exp_cc:3,   exp_to:0};
    tbl[6] = '{d:0, done_at:0,  vld:30,  rdy:50,  exp_cc:100, exp_to:1};
    tbl[7] = '{d:1, done_at:2,  vld:100, rdy:100, exp_cc:2,   exp_to:0};

    for (int k = 0; k < 2; k++) begin
      rst_s[k] = 1'b1; go_s[k] = 1'b1; iv_s[k] = 1'b0; id_s[k] = 8'd0;
      or_s[k] = 1'b0; dn_s[k] = 1'b0;
    end
    bd_we = 1'b1; bd_addr = 8'd0; bd_dat = 8'd0;

    // go is held high throughout reset; the blocks must stay idle.
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      bd_addr = 8'(k);
      bd_dat  = 8'($urandom);
      ref_mem[0][k] = bd_dat;
      ref_mem[1][k] = bd_dat;
    end
    @(negedge clk); bd_we = 1'b0; #1;

    for (int k = 0; k < 2; k++) begin
      chk("rst_start", st_s[k], 1);
      chk("rst_own", own_s[k], 1);
      chk("rst_busy", busy_s[k], 0);
      chk("rst_handshake", {ir_s[k], ov_s[k]}, 0);
      chk("rst_strobes", {wen_s[k], ren_s[k]}, 0);
      chk("rst_addr", addr_s[k], 0);
      chk("rst_wdata", wd_s[k], 0);
      chk("rst_out_data", od_s[k], 0);
      chk("rst_timed_out", to_s[k], 0);
      chk("rst_cycle_count", cc_s[k], 0);
      go_s[k] = 1'b0;
    end
    @(negedge clk); rst_s[0] = 1'b0; rst_s[1] = 1'b0; #1;
    chk("post_rst_idle", {busy_s[0], busy_s[1]}, 0);

    foreach (tbl[k])
      run_seq(tbl[k].d, tbl[k].done_at, tbl[k].vld, tbl[k].rdy, 0, tbl[k].exp_cc, tbl[k].exp_to);

    run_seq(0, 5, 70, 100, 1, 5, 0);
    run_seq(1, 4, 100, 100, 1, 4, 0);
    run_seq(1, 6, 100, 50, 0, 6, 0);

    for (int r = 0; r < 20; r++) begin
      d  = r % 2;
      da = $urandom_range(p_to[d] + 3);
      model_run(p_to[d], da, ecc, eto);
      run_seq(d, da, $urandom_range(100, 20), $urandom_range(100, 20), 0, ecc, eto);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Host-side run sequencer sitting directly upstream of the processor datapath. It streams host bytes into data memory while holding the core in init. It then drives the core's START input, times the program until DONE, and streams a result window of data memory back to the host. It owns the data-memory port whenever the core is held in init.

## Interface
Parameters:
- LOAD_BASE, 8'd0, first data-memory address written during load
- LOAD_LEN, 9'd64, bytes to load (0..256)
- OUT_BASE, 8'd64, first data-memory address read during drain
- OUT_LEN, 9'd64, bytes to drain (0..256)
- START_CYCLES, 4'd2, minimum cycles START is held before release (≥1)
- TIMEOUT, 16'hFFFF, RUN cycles before abort

Ports:
- CLK  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- go  in  1  begin a sequence; sampled only in IDLE
- in_valid  in  1  host load byte valid
- in_data  in  8  host load byte
- in_ready  out  1  block accepts in_data
- out_valid  out  1  result byte valid
- out_data  out  8  result byte
- out_ready  in  1  host accepts out_data
- START  out  1  core init, to datapath START
- DONE  in  1  core finished, from datapath DONE
- mem_own  out  1  1 = this block drives the data-memory port; 0 = core drives it
- mem_addr  out  8  data-memory address
- mem_wen, mem_ren  out  1  write and read strobes
- mem_wdata  out  8  write data
- mem_rdata  in  8  combinational read data
- busy  out  1  state ≠ IDLE
- timed_out  out  1  last run aborted on TIMEOUT
- cycle_count  out  16  RUN cycles of last run

## Operation
- States: IDLE, LOAD, INIT, RUN, DRAIN.
- IDLE
  - go=1 goes to LOAD, or to INIT if LOAD_LEN=0.
  - Clears timed_out, cycle_count and the index counter on the same edge.
- LOAD
  - in_ready=1, mem_own=1, mem_addr=LOAD_BASE+idx (mod 256), mem_wdata=in_data.
  - mem_wen=in_valid.
  - Each in_valid&in_ready increments idx.
  - The transfer with idx=LOAD_LEN-1 goes to INIT.
- INIT
  - START=1 for exactly START_CYCLES cycles, then go to RUN.
  - idx is reset to 0.
- RUN
  - START=0, mem_own=0, all mem strobes 0.
  - cycle_count increments each cycle and saturates at 16'hFFFF.
  - If DONE=1, go to DRAIN. DONE is sampled only in RUN, never in the first RUN cycle.
  - Otherwise, if cycle_count==TIMEOUT-1, set timed_out=1 and go to DRAIN.
  - DONE and timeout in the same cycle: DONE wins, timed_out stays 0.
- DRAIN
  - mem_own=1, mem_ren=1, mem_addr=OUT_BASE+idx (mod 256).
  - out_valid=1, out_data=mem_rdata (combinational).
  - Each out_valid&out_ready increments idx.
  - The last transfer goes to IDLE. If OUT_LEN=0, go straight to IDLE.
  - out_data is held stable while out_valid&!out_ready.
- START=1 in every state except RUN, so the core stays in init outside a run.
- go outside IDLE is ignored.
- in_ready=0 and out_valid=0 outside LOAD and DRAIN respectively.

## Timing
- Reset values:
  - state=IDLE, START=1, mem_own=1.
  - in_ready, out_valid, mem_wen, mem_ren = 0.
  - mem_addr, mem_wdata, out_data driven 0.
  - busy=0, timed_out=0, cycle_count=0.
- Reset mid-sequence aborts immediately and asynchronously. Memory contents are not restored.
- Load throughput: 1 byte/cycle. Write commits at the rising edge of the accepting cycle.
- Drain latency: out_data is valid in the same cycle mem_addr is presented (0-cycle read); 1 byte/cycle max.
- Full run with in_valid and out_ready held high: LOAD_LEN + START_CYCLES + (RUN cycles) + OUT_LEN cycles from go to IDLE.
- idx is 9-bit so that LEN=256 is representable. Addresses are truncated to 8 bits and wrap past 8'hFF.

## Structure
- A typedef enum logic [2:0] run_state_t {IDLE, LOAD, INIT, RUN, DRAIN} goes in the shared definitions package.
- The package also holds RUN_TIMEOUT_DEFAULT.
- Single module, no sub-module.
- The data-memory port mux between the core (reg_b_out/reg_a_out/CTRL_*) and this block, selected by mem_own, lives in the top level, not here.

## Test plan
- Reset then idle: reset=1 → START=1, mem_own=1, busy=0. go while reset=1 → no state change.
- Load 4 bytes (LOAD_LEN=4, LOAD_BASE=8'h10) of A1,B2,C3,D4 with in_valid gaps → mem writes at 10..13 in order. Then START=1 for exactly 2 cycles, then 0.
- RUN with DONE rising after 37 cycles → cycle_count=37, timed_out=0, mem_own=1 on the next cycle.
- TIMEOUT=8, DONE held 0 → timed_out=1, cycle_count=8, DRAIN entered. Variant with DONE rising on cycle 8 → timed_out=0.
- Drain OUT_BASE=8'hFE, OUT_LEN=3 with out_ready toggling → addresses FE,FF,00. out_data stable while stalled. Exactly 3 handshakes, then IDLE.
- Assert reset during DRAIN after 1 byte → IDLE immediately, out_valid=0. Next go with LOAD_LEN=0 → straight to INIT.
